data_memory_port: RTL and testbench

Single-port data memory with a valid/ready request/response interface, sitting directly downstream of the miniRV execute stage's load/store path. It accepts one word or byte access at a time (`lw`/`lbu`/`sw`/`sb`), inserts a configurable number of wait states, performs lane steering (the `sb` byte strobe and the `lbu` zero-extension), and returns read data plus an error flag. It replaces the core's ad-hoc combinational array so that multi-cycle memory can be modelled.

---
 rtl/miniRV_pkg.sv | 28 ++
 rtl/dmem_sram_array.sv | 35 +++
 rtl/data_memory_port.sv | 148 ++++++++++++++
 tb/tb_data_memory_port.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/miniRV_pkg.sv
// +----------------------------------------------------------------------------+
// | miniRV_pkg : shared types and helpers for the miniRV data memory port       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package miniRV_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam logic ACC_BYTE = 1'b1;
  localparam logic ACC_WORD = 1'b0;

  // Byte strobe for an access: one lane for sb/lbu, all four for sw/lw.
  function automatic logic [3:0] lane_mask(input logic [1:0] lane, input logic is_byte);
    if (is_byte == ACC_BYTE) begin
      return 4'b0001 << lane;
    end
    return 4'b1111;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_sram_array.sv
// +----------------------------------------------------------------------------+
// | dmem_sram_array : DEPTH_WORDS x 32 storage, async read, byte-enable write   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module dmem_sram_array #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [3:0]                     be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // Contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          r_mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = r_mem[addr];

endmodule

`default_nettype wire

// File: rtl/data_memory_port.sv
// +----------------------------------------------------------------------------+
// | data_memory_port : valid/ready data memory with wait states and lane steer  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module data_memory_port
  import miniRV_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          c_aw         = $clog2(DEPTH_WORDS);
  localparam logic [29:0] c_depth      = 30'(DEPTH_WORDS);
  localparam logic        c_zero_wait  = (WAIT_CYCLES == 0);
  localparam logic [3:0]  c_count_init = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  dmem_state_t r_state;
  dmem_state_t w_next_state;
  logic [3:0]  r_count;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic        r_byte;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic        w_accept;
  logic        w_exec;
  logic [31:0] w_acc_addr;
  logic [31:0] w_acc_wdata;
  logic        w_acc_we;
  logic        w_acc_byte;
  logic        w_err;
  logic [31:0] w_rd_word;
  logic [7:0]  w_rd_lane;
  logic [31:0] w_rd_data;
  logic [31:0] w_wr_data;

  assign w_accept = (r_state == IDLE) && req_valid;

  // With zero wait states the access runs on the accept edge, so it must use
  // the live request rather than the not-yet-latched copy.
  assign w_acc_addr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_acc_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_acc_we    = (r_state == IDLE) ? req_we    : r_we;
  assign w_acc_byte  = (r_state == IDLE) ? req_byte  : r_byte;

  assign w_exec = (w_accept && c_zero_wait) || ((r_state == BUSY) && (r_count == 4'd0));

  assign w_err = ((w_acc_byte == ACC_WORD) && (w_acc_addr[1:0] != 2'b00))
               || (w_acc_addr[31:2] >= c_depth);

  assign w_wr_data = (w_acc_byte == ACC_BYTE) ? {4{w_acc_wdata[7:0]}} : w_acc_wdata;
  assign w_rd_lane = w_rd_word[{w_acc_addr[1:0], 3'b000} +: 8];

  dmem_sram_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_sram (
    .clk  (clk),
    .we   (w_exec && w_acc_we && !w_err),
    .be   (lane_mask(w_acc_addr[1:0], w_acc_byte)),
    .addr (w_acc_addr[c_aw+1:2]),
    .wdata(w_wr_data),
    .rdata(w_rd_word)
  );

  always_comb begin
    w_rd_data = 32'h0;
    if (!w_err && !w_acc_we) begin
      w_rd_data = (w_acc_byte == ACC_BYTE) ? {24'h0, w_rd_lane} : w_rd_word;
    end
  end

  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next_state = c_zero_wait ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (r_count == 4'd0) begin
          w_next_state = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_count     <= 4'd0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_we        <= 1'b0;
      r_byte      <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_we    <= req_we;
        r_byte  <= req_byte;
        r_count <= c_count_init;
      end else if ((r_state == BUSY) && (r_count != 4'd0)) begin
        r_count <= r_count - 4'd1;
      end
      if (w_exec) begin
        r_rsp_rdata <= w_rd_data;
        r_rsp_err   <= w_err;
      end
    end
  end

  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_data_memory_port.sv
// +----------------------------------------------------------------------------+
// | tb_data_memory_port : directed bench over WAIT_CYCLES = 1, 3 and 0 instances|
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_data_memory_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Index 0: WAIT=1 depth 1024, index 1: WAIT=3 depth 16, index 2: WAIT=0 depth 16
  logic        rst   [3];
  logic        rv    [3];
  logic        rwe   [3];
  logic        rby   [3];
  logic        rr    [3];
  logic [31:0] ra    [3];
  logic [31:0] rwd   [3];
  logic        rdy   [3];
  logic        sv    [3];
  logic [31:0] sdata [3];
  logic        serr  [3];

  int vectors = 0;
  int errors  = 0;

  data_memory_port #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(rst[0]), .req_valid(rv[0]), .req_ready(rdy[0]), .req_addr(ra[0]),
    .req_we(rwe[0]), .req_byte(rby[0]), .req_wdata(rwd[0]), .rsp_valid(sv[0]),
    .rsp_ready(rr[0]), .rsp_rdata(sdata[0]), .rsp_err(serr[0]));

  data_memory_port #(.DEPTH_WORDS(16), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(rst[1]), .req_valid(rv[1]), .req_ready(rdy[1]), .req_addr(ra[1]),
    .req_we(rwe[1]), .req_byte(rby[1]), .req_wdata(rwd[1]), .rsp_valid(sv[1]),
    .rsp_ready(rr[1]), .rsp_rdata(sdata[1]), .rsp_err(serr[1]));

  data_memory_port #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(rst[2]), .req_valid(rv[2]), .req_ready(rdy[2]), .req_addr(ra[2]),
    .req_we(rwe[2]), .req_byte(rby[2]), .req_wdata(rwd[2]), .rsp_valid(sv[2]),
    .rsp_ready(rr[2]), .rsp_rdata(sdata[2]), .rsp_err(serr[2]));

  // Called 1 time unit after an edge with the target in IDLE; returns 1 time unit
  // after the response handshake edge. lat counts cycles from the accept cycle.
  task automatic access(input int d, input logic we, input logic by, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output int acc_cyc);
    rv[d] = 1'b1; rwe[d] = we; rby[d] = by; ra[d] = addr; rwd[d] = wd;
    acc_cyc = cyc;
    @(posedge clk); #1;
    rv[d] = 1'b0;
    lat = 1;
    while (sv[d] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (sv[d] !== 1'b1) begin
      vectors++; errors++;
      $display("FAIL timeout dut%0d addr=%h: no rsp_valid within %0d cycles", d, addr, lat);
    end
    rd = sdata[d];
    er = serr[d];
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin rst[d] = 1'b1; rv[d] = 1'b0; rr[d] = 1'b1; end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if ({rdy[d], sv[d], sdata[d], serr[d]} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
        errors++;
        $display("FAIL reset dut%0d: ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
                 d, rdy[d], sv[d], sdata[d], serr[d]);
      end
      rst[d] = 1'b0;
    end
  endtask

  task automatic test_word_round_trip();
    logic [31:0] rd; logic er; int lat, ac;
    access(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat, ac);
    vectors++;
    if ({rd, er} !== {32'h0, 1'b0} || lat !== 2) begin
      errors++;
      $display("FAIL sw_0x10: rdata=%h err=%b lat=%0d, want 0 0 2", rd, er, lat);
    end
    access(0, 1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat, ac);
    vectors++;
    if ({rd, er} !== {32'hDEADBEEF, 1'b0} || lat !== 2) begin
      errors++;
      $display("FAIL lw_0x10: rdata=%h err=%b lat=%0d, want deadbeef 0 2", rd, er, lat);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic er; int lat, ac;
    logic [31:0] addrs [4] = '{32'h20, 32'h23, 32'h22, 32'h20};
    logic        bys   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] exps  [4] = '{32'h11AA3344, 32'h11, 32'hAA, 32'h44};
    access(0, 1'b1, 1'b0, 32'h20, 32'h11223344, rd, er, lat, ac);
    access(0, 1'b1, 1'b1, 32'h22, 32'hFFFFFFAA, rd, er, lat, ac);
    vectors++;
    if ({rd, er} !== {32'h0, 1'b0}) begin
      errors++;
      $display("FAIL sb_0x22: rdata=%h err=%b, want 0 0", rd, er);
    end
    for (int i = 0; i < 4; i++) begin
      access(0, 1'b0, bys[i], addrs[i], 32'h0, rd, er, lat, ac);
      vectors++;
      if ({rd, er} !== {exps[i], 1'b0}) begin
        errors++;
        $display("FAIL lane_load[%0d] addr=%h byte=%b: rdata=%h err=%b, want %h 0",
                 i, addrs[i], bys[i], rd, er, exps[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat, ac;
    logic [31:0] addrs [5] = '{32'h21, 32'h1000, 32'h1002, 32'h21, 32'h20};
    logic        wes   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        bys   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] expd  [5] = '{32'h0, 32'h0, 32'h0, 32'h33, 32'h11AA3344};
    logic        expe  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      access(0, wes[i], bys[i], addrs[i], 32'h0, rd, er, lat, ac);
      vectors++;
      if ({rd, er} !== {expd[i], expe[i]}) begin
        errors++;
        $display("FAIL err_case[%0d] addr=%h we=%b byte=%b: rdata=%h err=%b, want %h %b",
                 i, addrs[i], wes[i], bys[i], rd, er, expd[i], expe[i]);
      end
    end
    access(0, 1'b1, 1'b0, 32'hFFC, 32'hCAFEF00D, rd, er, lat, ac);
    access(0, 1'b0, 1'b0, 32'hFFC, 32'h0, rd, er, lat, ac);
    vectors++;
    if ({rd, er} !== {32'hCAFEF00D, 1'b0}) begin
      errors++;
      $display("FAIL last_word: rdata=%h err=%b, want cafef00d 0", rd, er);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat, ac;
    int guard = 0;
    rr[0] = 1'b0;
    rv[0] = 1'b1; rwe[0] = 1'b0; rby[0] = 1'b0; ra[0] = 32'h20;
    @(posedge clk); #1;
    rv[0] = 1'b1; rwe[0] = 1'b1; rby[0] = 1'b0; ra[0] = 32'h20; rwd[0] = 32'h0;
    while (sv[0] !== 1'b1 && guard < 40) begin @(posedge clk); #1; guard++; end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({sv[0], rdy[0], sdata[0], serr[0]} !== {1'b1, 1'b0, 32'h11AA3344, 1'b0}) begin
        errors++;
        $display("FAIL hold[%0d]: valid=%b ready=%b rdata=%h err=%b, want 1 0 11aa3344 0",
                 i, sv[0], rdy[0], sdata[0], serr[0]);
      end
      @(posedge clk); #1;
    end
    rv[0] = 1'b0; rr[0] = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({sv[0], rdy[0]} !== 2'b01) begin
      errors++;
      $display("FAIL release: valid=%b ready=%b, want 0 1", sv[0], rdy[0]);
    end
    access(0, 1'b0, 1'b0, 32'h20, 32'h0, rd, er, lat, ac);
    vectors++;
    if ({rd, er} !== {32'h11AA3344, 1'b0}) begin
      errors++;
      $display("FAIL ignored_store: rdata=%h err=%b, want 11aa3344 0", rd, er);
    end
  endtask

  task automatic test_reset_in_busy();
    logic [31:0] rd; logic er; int lat, ac;
    access(1, 1'b1, 1'b0, 32'h30, 32'h0, rd, er, lat, ac);
    vectors++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL wait3_latency: lat=%0d, want 4", lat);
    end
    rv[1] = 1'b1; rwe[1] = 1'b1; rby[1] = 1'b0; ra[1] = 32'h30; rwd[1] = 32'h55;
    @(posedge clk); #1;
    rv[1] = 1'b0; rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    vectors++;
    if ({sv[1], rdy[1]} !== 2'b01) begin
      errors++;
      $display("FAIL busy_reset: valid=%b ready=%b, want 0 1", sv[1], rdy[1]);
    end
    access(1, 1'b0, 1'b0, 32'h30, 32'h0, rd, er, lat, ac);
    vectors++;
    if ({rd, er} !== {32'h0, 1'b0}) begin
      errors++;
      $display("FAIL abandoned_store: rdata=%h err=%b, want 0 0", rd, er);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat, ac, prev;
    logic [31:0] vals [4] = '{32'h01020304, 32'hA5A5A5A5, 32'h0BADF00D, 32'h76543210};
    for (int i = 0; i < 4; i++) access(2, 1'b1, 1'b0, 32'(4 * i), vals[i], rd, er, lat, ac);
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      access(2, 1'b0, 1'b0, 32'(4 * i), 32'h0, rd, er, lat, ac);
      vectors++;
      if ({rd, er} !== {vals[i], 1'b0} || lat !== 1 || (i > 0 && ac - prev !== 2)) begin
        errors++;
        $display("FAIL stream[%0d]: rdata=%h err=%b lat=%0d gap=%0d, want %h 0 1 2",
                 i, rd, er, lat, ac - prev, vals[i]);
      end
      prev = ac;
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; rv[d] = 1'b0; rwe[d] = 1'b0; rby[d] = 1'b0; rr[d] = 1'b1;
      ra[d] = 32'h0; rwd[d] = 32'h0;
    end
    test_reset();
    test_word_round_trip();
    test_byte_lanes();
    test_errors();
    test_backpressure();
    test_reset_in_busy();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
